matmul_ctrl_param: RTL and testbench

- Parametrised control FSM for a ROWS x COLS matrix-vector multiplier.
- Loads a weight matrix W into weight RAM, then a vector X into vector RAM, over one valid/ready input stream.
- Sequences one multiply-accumulate (MAC) pass per row and hands each row result out on a valid/ready output handshake.
- Beyond a fixed 8x8 controller: configurable dimensions, configurable accumulator pipeline latency, weight-reuse tracking and a no-weights error flag.

---
 rtl/matmul_ctrl_param.sv | 186 ++++++++++++++++++
 tb/tb_matmul_ctrl_param.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_ctrl_param.sv
// Control FSM for a ROWS x COLS matrix-vector multiplier: streams W then X into RAM,
// runs one MAC pass per row and hands each row result out on a valid/ready port.
module matmul_ctrl_param #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int ACC_LAT = 1,
  localparam int WW = ($clog2(ROWS * COLS) > 1) ? $clog2(ROWS * COLS) : 1,
  localparam int XW = ($clog2(COLS) > 1) ? $clog2(COLS) : 1,
  localparam int RW = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          input_valid,
  output logic          input_ready,
  input  logic          new_matrix,
  input  logic          output_ready,
  output logic          output_valid,
  output logic [RW-1:0] row_idx,
  output logic          last_row,
  output logic [WW-1:0] addr_w,
  output logic          wr_en_w,
  output logic [XW-1:0] addr_x,
  output logic          wr_en_x,
  output logic          clear_acc,
  output logic          en_acc,
  output logic          w_loaded,
  output logic          err_no_w
);

  localparam int DW = ($clog2(ACC_LAT) > 1) ? $clog2(ACC_LAT) : 1;
  localparam logic [WW-1:0] LAST_W   = WW'(ROWS * COLS - 1);
  localparam logic [XW-1:0] LAST_X   = XW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [DW-1:0] LAST_D   = DW'(ACC_LAT - 1);

  typedef enum logic [2:0] {
    INIT, IDLE, LOAD_W, LOAD_X, MULT, DRAIN, SEND
  } state_t;

  state_t          state, state_n;
  logic [WW-1:0]   wptr, wptr_n;
  logic [XW-1:0]   xptr, xptr_n;
  logic [XW-1:0]   kcnt, kcnt_n;
  logic [RW-1:0]   row, row_n;
  logic [DW-1:0]   dcnt, dcnt_n;
  logic            w_loaded_n;
  logic            acc_req;
  logic [ACC_LAT-1:0] acc_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      wptr     <= '0;
      xptr     <= '0;
      kcnt     <= '0;
      row      <= '0;
      dcnt     <= '0;
      w_loaded <= 1'b0;
      acc_pipe <= '0;
    end else begin
      state    <= state_n;
      wptr     <= wptr_n;
      xptr     <= xptr_n;
      kcnt     <= kcnt_n;
      row      <= row_n;
      dcnt     <= dcnt_n;
      w_loaded <= w_loaded_n;
      acc_pipe[0] <= acc_req;
      for (int i = 1; i < ACC_LAT; i++) acc_pipe[i] <= acc_pipe[i-1];
    end
  end

  // Accumulator enable trails the address issue by the RAM/multiplier latency.
  assign en_acc = acc_pipe[ACC_LAT-1];

  always_comb begin
    state_n      = state;
    wptr_n       = wptr;
    xptr_n       = xptr;
    kcnt_n       = kcnt;
    row_n        = row;
    dcnt_n       = dcnt;
    w_loaded_n   = w_loaded;
    acc_req      = 1'b0;
    input_ready  = 1'b0;
    output_valid = 1'b0;
    row_idx      = '0;
    last_row     = 1'b0;
    addr_w       = '0;
    wr_en_w      = 1'b0;
    addr_x       = '0;
    wr_en_x      = 1'b0;
    clear_acc    = 1'b0;
    err_no_w     = 1'b0;

    case (state)
      INIT: begin
        clear_acc = 1'b1;
        state_n   = IDLE;
      end
      IDLE: begin
        input_ready = 1'b1;
        if (input_valid) begin
          if (new_matrix) begin
            wr_en_w    = 1'b1;
            wptr_n     = WW'(1);
            w_loaded_n = 1'b0;
            state_n    = LOAD_W;
          end else if (w_loaded) begin
            wr_en_x = 1'b1;
            xptr_n  = XW'(1);
            state_n = LOAD_X;
          end else begin
            err_no_w = 1'b1;
          end
        end
      end
      LOAD_W: begin
        input_ready = 1'b1;
        addr_w      = wptr;
        wr_en_w     = input_valid;
        if (input_valid) begin
          if (wptr == LAST_W) begin
            wptr_n     = '0;
            w_loaded_n = 1'b1;
            xptr_n     = '0;
            state_n    = LOAD_X;
          end else begin
            wptr_n = wptr + WW'(1);
          end
        end
      end
      LOAD_X: begin
        input_ready = 1'b1;
        addr_x      = xptr;
        wr_en_x     = input_valid;
        if (input_valid) begin
          if (xptr == LAST_X) begin
            xptr_n  = '0;
            kcnt_n  = '0;
            row_n   = '0;
            wptr_n  = '0;
            state_n = MULT;
          end else begin
            xptr_n = xptr + XW'(1);
          end
        end
      end
      // wptr runs on across rows, so row r naturally reads r*COLS onwards.
      MULT: begin
        addr_w  = wptr;
        addr_x  = kcnt;
        acc_req = 1'b1;
        wptr_n  = wptr + WW'(1);
        if (kcnt == LAST_X) begin
          kcnt_n  = '0;
          dcnt_n  = '0;
          state_n = DRAIN;
        end else begin
          kcnt_n = kcnt + XW'(1);
        end
      end
      DRAIN: begin
        if (dcnt == LAST_D) state_n = SEND;
        else                dcnt_n  = dcnt + DW'(1);
      end
      SEND: begin
        output_valid = 1'b1;
        row_idx      = row;
        last_row     = (row == LAST_ROW);
        if (output_ready) begin
          clear_acc = 1'b1;
          if (row == LAST_ROW) begin
            wptr_n  = '0;
            state_n = IDLE;
          end else begin
            row_n   = row + RW'(1);
            state_n = MULT;
          end
        end
      end
      default: state_n = INIT;
    endcase
  end

endmodule

// File: tb/tb_matmul_ctrl_param.sv
// Self-checking bench for matmul_ctrl_param: vector table for reset/IDLE corners,
// scoreboarded jobs on the default instance, and a 4x16 / ACC_LAT=3 instance.
module tb_matmul_ctrl_param;

  localparam int ROWS = 8, COLS = 8, ACC_LAT = 1;
  localparam int R2 = 4, C2 = 16, L2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, input_valid, new_matrix, output_ready;
  logic input_ready, output_valid, last_row, wr_en_w, wr_en_x, clear_acc, en_acc, w_loaded, err_no_w;
  logic [2:0] row_idx;
  logic [5:0] addr_w;
  logic [2:0] addr_x;

  logic rst2, input_valid2, new_matrix2, output_ready2;
  logic input_ready2, output_valid2, last_row2, wr_en_w2, wr_en_x2, clear_acc2, en_acc2, w_loaded2, err_no_w2;
  logic [1:0] row_idx2;
  logic [5:0] addr_w2;
  logic [3:0] addr_x2;

  matmul_ctrl_param #(.ROWS(ROWS), .COLS(COLS), .ACC_LAT(ACC_LAT)) dut (
    .clk(clk), .rst(rst), .input_valid(input_valid), .input_ready(input_ready),
    .new_matrix(new_matrix), .output_ready(output_ready), .output_valid(output_valid),
    .row_idx(row_idx), .last_row(last_row), .addr_w(addr_w), .wr_en_w(wr_en_w),
    .addr_x(addr_x), .wr_en_x(wr_en_x), .clear_acc(clear_acc), .en_acc(en_acc),
    .w_loaded(w_loaded), .err_no_w(err_no_w)
  );

  matmul_ctrl_param #(.ROWS(R2), .COLS(C2), .ACC_LAT(L2)) dut2 (
    .clk(clk), .rst(rst2), .input_valid(input_valid2), .input_ready(input_ready2),
    .new_matrix(new_matrix2), .output_ready(output_ready2), .output_valid(output_valid2),
    .row_idx(row_idx2), .last_row(last_row2), .addr_w(addr_w2), .wr_en_w(wr_en_w2),
    .addr_x(addr_x2), .wr_en_x(wr_en_x2), .clear_acc(clear_acc2), .en_acc(en_acc2),
    .w_loaded(w_loaded2), .err_no_w(err_no_w2)
  );

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int row; logic last; } res_t;
  int   wq[$];
  int   xq[$];
  res_t rq[$];
  res_t rq2[$];

  typedef struct {
    logic rst, iv, nm;
    logic e_ready, e_clear, e_err, e_wrw, e_wrx, e_wl;
    logic [5:0] e_addrw;
  } vec_t;
  vec_t tbl[11];

  bit sb_on = 0;
  int ww_count, wx_count, en_count, read_ptr, prev_addr_w, prev_addr_x;
  int first_en_cyc, first_valid_cyc, last_x_cyc, clear_in_send;
  int valid_cyc[ROWS];
  logic prev_valid = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, wanted %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic nm, input logic ordy);
    @(posedge clk);
    #1;
    input_valid  = iv;
    new_matrix   = nm;
    output_ready = ordy;
  endtask

  task automatic resetMonitor();
    ww_count = 0; wx_count = 0; en_count = 0; read_ptr = 0; clear_in_send = 0;
    first_en_cyc = -1; first_valid_cyc = -1;
    foreach (valid_cyc[i]) valid_cyc[i] = 0;
  endtask

  // Scoreboard monitor: RAM writes, MAC read order behind en_acc, and row results.
  always @(negedge clk) begin
    res_t r;
    int   e;
    if (sb_on) begin
      if (wr_en_w) begin
        ww_count++;
        e = (wq.size() > 0) ? wq.pop_front() : -1;
        checkOutput("w_write_addr", addr_w, e);
      end
      if (wr_en_x) begin
        wx_count++;
        e = (xq.size() > 0) ? xq.pop_front() : -1;
        checkOutput("x_write_addr", addr_x, e);
      end
      if (en_acc) begin
        en_count++;
        if (first_en_cyc < 0) first_en_cyc = cyc;
        checkOutput("mac_addr_w", prev_addr_w, read_ptr);
        checkOutput("mac_addr_x", prev_addr_x, read_ptr % COLS);
        read_ptr++;
      end
      if (output_valid) begin
        valid_cyc[row_idx]++;
        if (!prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (clear_acc) clear_in_send++;
      end
      if (output_valid && output_ready) begin
        if (rq.size() > 0) r = rq.pop_front();
        else begin r.row = -1; r.last = 1'b0; end
        checkOutput("result_row", row_idx, r.row);
        checkOutput("result_last_row", last_row, r.last);
      end
      prev_valid  = output_valid;
      prev_addr_w = addr_w;
      prev_addr_x = addr_x;
    end
  end

  task automatic loadW(input bit gaps);
    for (int i = 0; i < ROWS*COLS; i++) begin
      applyStimulus(1'b1, (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1);
      wq.push_back(i);
      if (i == ROWS*COLS-1) begin
        @(negedge clk);
        checkOutput("w_loaded_before_last", w_loaded, 0);
      end
      if (gaps) applyStimulus(1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic loadX();
    for (int j = 0; j < COLS; j++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      xq.push_back(j);
      if (j == 0) begin
        @(negedge clk);
        checkOutput("w_loaded_at_x", w_loaded, 1);
      end
    end
    last_x_cyc = cyc;
    for (int r = 0; r < ROWS; r++) rq.push_back('{r, (r == ROWS-1)});
    applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  task automatic drainResults(input int stall_row, input int stall_cycles);
    int left = stall_cycles;
    int guard = 0;
    while (rq.size() > 0 && guard < 400) begin
      @(posedge clk);
      #1;
      guard++;
      if (output_valid && row_idx == 3'(stall_row) && left > 0) begin
        output_ready = 1'b0;
        left--;
      end else output_ready = 1'b1;
    end
    checkOutput("results_pending", rq.size(), 0);
    checkOutput("idle_after_job", input_ready, 1);
  endtask

  task automatic checkJob(input int exp_w_writes);
    checkOutput("first_valid_latency", first_valid_cyc - last_x_cyc, COLS + ACC_LAT + 1);
    checkOutput("first_en_delay", first_en_cyc - last_x_cyc, 1 + ACC_LAT);
    checkOutput("en_acc_count", en_count, ROWS*COLS);
    checkOutput("clear_in_send", clear_in_send, ROWS);
    checkOutput("w_write_count", ww_count, exp_w_writes);
    checkOutput("x_write_count", wx_count, COLS);
    checkOutput("w_queue_left", wq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    res_t r2;
    int   k2, en_row, first_en2, first_valid2, guard;

    rst = 1'b1; input_valid = 1'b0; new_matrix = 1'b0; output_ready = 1'b1;
    rst2 = 1'b1; input_valid2 = 1'b0; new_matrix2 = 1'b0; output_ready2 = 1'b1;

    //              rst iv nm  rdy clr err wrw wrx wl  addr_w
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd2};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};

    repeat (2) @(posedge clk);
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      #1;
      rst = tbl[i].rst; input_valid = tbl[i].iv; new_matrix = tbl[i].nm;
      @(negedge clk);
      checkOutput($sformatf("vec%0d_input_ready", i), input_ready, tbl[i].e_ready);
      checkOutput($sformatf("vec%0d_clear_acc", i), clear_acc, tbl[i].e_clear);
      checkOutput($sformatf("vec%0d_err_no_w", i), err_no_w, tbl[i].e_err);
      checkOutput($sformatf("vec%0d_wr_en_w", i), wr_en_w, tbl[i].e_wrw);
      checkOutput($sformatf("vec%0d_wr_en_x", i), wr_en_x, tbl[i].e_wrx);
      checkOutput($sformatf("vec%0d_w_loaded", i), w_loaded, tbl[i].e_wl);
      checkOutput($sformatf("vec%0d_addr_w", i), addr_w, tbl[i].e_addrw);
    end

    // Job 1: full load, no gaps, no back-pressure.
    sb_on = 1;
    resetMonitor();
    loadW(0);
    loadX();
    drainResults(-1, 0);
    checkJob(ROWS*COLS);

    // Job 2: gapped W load, row 3 held off for 5 cycles.
    resetMonitor();
    loadW(1);
    loadX();
    drainResults(3, 5);
    checkJob(ROWS*COLS);
    checkOutput("row3_valid_cycles", valid_cyc[3], 6);
    checkOutput("row4_valid_cycles", valid_cyc[4], 1);

    // Job 3: X-only job reusing stored weights.
    resetMonitor();
    loadX();
    drainResults(-1, 0);
    checkJob(0);

    // Job 4: reset in the middle of row 2.
    resetMonitor();
    loadX();
    guard = 0;
    while (rq.size() > ROWS-2 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rows_before_reset", rq.size(), ROWS-2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("en_acc_before_reset", en_acc, 1);
    rst = 1'b1;
    sb_on = 0;
    @(posedge clk); #1;
    checkOutput("rst_clear_acc", clear_acc, 1);
    checkOutput("rst_en_acc", en_acc, 0);
    checkOutput("rst_w_loaded", w_loaded, 0);
    checkOutput("rst_input_ready", input_ready, 0);
    checkOutput("rst_output_valid", output_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_idle_ready", input_ready, 1);
    checkOutput("post_rst_clear_acc", clear_acc, 0);
    rq.delete(); xq.delete(); wq.delete();

    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("xonly_err_no_w", err_no_w, 1);
    checkOutput("xonly_wr_en_x", wr_en_x, 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("xonly_still_idle_err", err_no_w, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("xonly_err_pulse_end", err_no_w, 0);

    // 4x16 instance with a 3-cycle accumulator latency.
    @(posedge clk); #1;
    rst2 = 1'b0;
    for (int i = 0; i < R2*C2; i++) begin
      @(posedge clk); #1;
      input_valid2 = 1'b1; new_matrix2 = (i == 0);
      @(negedge clk);
      checkOutput("d2_w_write", wr_en_w2 ? 32'(addr_w2) : -1, i);
    end
    for (int j = 0; j < C2; j++) begin
      @(posedge clk); #1;
      new_matrix2 = 1'b0;
      @(negedge clk);
      checkOutput("d2_x_write", wr_en_x2 ? 32'(addr_x2) : -1, j);
    end
    k2 = cyc;
    for (int r = 0; r < R2; r++) rq2.push_back('{r, (r == R2-1)});
    @(posedge clk); #1;
    input_valid2 = 1'b0;
    en_row = 0; first_en2 = -1; first_valid2 = -1;
    for (int c = 0; c < 400 && rq2.size() > 0; c++) begin
      @(negedge clk);
      if (en_acc2) begin
        en_row++;
        if (first_en2 < 0) first_en2 = cyc;
      end
      if (output_valid2 && first_valid2 < 0) first_valid2 = cyc;
      if (output_valid2 && output_ready2) begin
        r2 = rq2.pop_front();
        checkOutput("d2_result_row", row_idx2, r2.row);
        checkOutput("d2_result_last_row", last_row2, r2.last);
        checkOutput("d2_en_per_row", en_row, C2);
        en_row = 0;
      end
    end
    checkOutput("d2_results_pending", rq2.size(), 0);
    checkOutput("d2_first_valid_latency", first_valid2 - k2, C2 + L2 + 1);
    checkOutput("d2_first_en_delay", first_en2 - k2, 1 + L2);
    @(posedge clk); #1;
    checkOutput("d2_idle_after_job", input_ready2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
